ibex_pad_mem_ctrl: RTL and testbench
====================================

Name: ibex_pad_mem_ctrl

Overview:
- Sequences the pin-limited off-chip memory link of the chip top.
- Accepts OBI-style instruction and data requests from the ibex core and arbitrates between them.
- Serialises command, address and write data onto an 8-bit pad output bus, then reassembles 32-bit read data or a write acknowledgement from an 8-bit pad input bus.
- One transaction in flight at a time, shared by both ports.

Parameters:
TimeoutCycles, 64, response-wait limit in cycles; 0 disables timeout
TimeoutW, 8, width of the timeout counter; must satisfy TimeoutCycles < 2**TimeoutW

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
instr_req_i  in  1  core instruction request
instr_gnt_o  out  1  instruction grant
instr_rvalid_o  out  1  instruction response valid, 1-cycle pulse
instr_addr_i  in  32  fetch address
instr_rdata_o  out  32  fetch data
instr_err_o  out  1  fetch error, valid with rvalid
data_req_i  in  1  core data request
data_gnt_o  out  1  data grant
data_rvalid_o  out  1  data response valid, 1-cycle pulse
data_we_i  in  1  1 = write
data_be_i  in  4  byte enables
data_addr_i  in  32  data address
data_wdata_i  in  32  write data
data_rdata_o  out  32  read data
data_err_o  out  1  data error, valid with rvalid
pad_out_o  out  8  serial beat to pads
pad_out_valid_o  out  1  pad_out_o carries a beat
pad_in_i  in  8  serial beat from pads
pad_in_valid_i  in  1  pad_in_i carries a beat

Behaviour:
- Reset (rst_ni low at a clock edge):
  - State goes to IDLE and the last-served register is set to DATA.
  - Beat counter and timeout counter clear.
  - Every output is 0 from the next cycle, including pad_out_o = 8'h00. Any transaction in flight is dropped and no rvalid is issued for it.
- States: IDLE, HDR, ADDR, WDATA, RESP, RSPV.
- IDLE:
  - gnt is combinational and only asserted in IDLE.
  - If exactly one req is high, that port is granted in the same cycle.
  - If both are high, the port not served last wins (round-robin). After reset, instr wins the first tie.
  - On grant, latch cmd, be, addr and wdata, update last-served, and go to HDR.
- Command encoding (cmd):
  - IFETCH = 2'b01, be is forced to 4'hF.
  - DREAD = 2'b10.
  - DWRITE = 2'b11.
- HDR: 1 cycle. pad_out_valid_o = 1, pad_out_o = {cmd, be, 2'b00}.
- ADDR: 4 cycles, address bytes LSB first (addr[7:0] first).
  - Then go to WDATA if DWRITE, else RESP.
- WDATA: 4 cycles, wdata bytes LSB first, then go to RESP.
- pad_out_valid_o = 1 exactly in HDR, ADDR and WDATA. Otherwise it is 0 and pad_out_o = 8'h00.
- RESP:
  - Reads capture 4 beats on pad_in_valid_i, LSB first, into rdata[8k+7:8k].
  - Writes capture 1 ack beat; err = pad_in_i[0].
  - pad_in_valid_i is ignored outside RESP.
  - The timeout counter increments on every RESP cycle without a beat and clears on each beat.
  - If TimeoutCycles != 0 and the counter reaches TimeoutCycles: err = 1, rdata = 0, go to RSPV.
  - After the last beat: go to RSPV.
- RSPV: 1 cycle.
  - rvalid of the owning port is 1. Its rdata and err are held stable from RSPV until the next grant of that port.
  - The other port's rvalid stays 0. Go to IDLE.
- Minimum latency, with grant in cycle T0:
  - Read: header at T1, addr T2–T5, response beats T6–T9, rvalid T10.
  - Write: wdata T6–T9, ack T10, rvalid T11.
- req held high without a grant is not consumed. The core keeps its address stable until gnt.

Decomposition:
- Package ibex_pad_pkg:
  - pad_cmd_e (IFETCH, DREAD, DWRITE).
  - pad_state_e.
  - Constants: AddrBeats = 4, DataBeats = 4, BeatW = 8.
- Sub-module ibex_pad_rr_arb: 2-way round-robin arbiter with a last-served register. Inputs: req[1:0], an advance strobe and clk/rst. Output: one-hot gnt.

Test Plan:
1. Instr fetch, addr 0x00000080.
   - Expect pad out 0x7C, 0x80, 0x00, 0x00, 0x00.
   - Drive pad in 0x13, 0x00, 0x00, 0x00 back-to-back.
   - Expect instr_rvalid_o one cycle after the last beat, instr_rdata_o = 0x00000013, err 0, data_rvalid_o 0.
2. Data write, addr 0x10000004, wdata 0xDEADBEEF, be 4'b0011.
   - Expect pad out 0xCC, 04, 00, 00, 10, EF, BE, AD, DE.
   - Ack 0x00 → data_rvalid_o with err 0. A second write acked with 0x01 → data_err_o = 1.
3. Both reqs held high from reset.
   - Expect instr granted first, data granted at the next IDLE, then instr again.
   - At most one gnt per cycle, and no gnt outside IDLE.
4. TimeoutCycles = 16, data read with no pad_in_valid_i.
   - Expect data_rvalid_o 17 cycles after entering RESP, err 1, rdata 0.
   - Repeat with a beat after 10 idle cycles: the counter restarts and no timeout occurs.
5. rst_ni low for one cycle during the 3rd ADDR beat.
   - Expect pad_out_valid_o = 0 next cycle, no rvalid, and all outputs 0.
   - A subsequent fetch completes normally, with instr winning a tie.
6. Read with gaps: beats at random spacing under the timeout.
   - Expect correct byte assembly, e.g. 0x11, 0x22, 0x33, 0x44 → 0x44332211.

Source files
------------

// File: rtl/ibex_pad_mem_ctrl_pkg.sv
// Shared types and constants for the pin-limited off-chip memory link.
// Beats are BeatW bits wide; addresses and data words split into 4 beats each.
package ibex_pad_pkg;

   localparam int AddrBeats = 4;
   localparam int DataBeats = 4;
   localparam int BeatW     = 8;

   typedef enum logic [1:0] {
      IFETCH = 2'b01,
      DREAD  = 2'b10,
      DWRITE = 2'b11
   } pad_cmd_e;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      ADDR,
      WDATA,
      RESP,
      RSPV
   } pad_state_e;

   function automatic logic [BeatW-1:0] hdr_beat(input pad_cmd_e cmd, input logic [3:0] be);
      return {cmd, be, 2'b00};
   endfunction

endpackage

// File: rtl/ibex_pad_mem_ctrl_if.sv
// Core-side OBI ports and pad-side serial link of the memory controller.
// The slave modport is the controller's view; master is the core/pad side.
interface ibex_pad_mem_ctrl_if;
   import ibex_pad_pkg::*;

   logic             instr_req_i;
   logic             instr_gnt_o;
   logic             instr_rvalid_o;
   logic [31:0]      instr_addr_i;
   logic [31:0]      instr_rdata_o;
   logic             instr_err_o;

   logic             data_req_i;
   logic             data_gnt_o;
   logic             data_rvalid_o;
   logic             data_we_i;
   logic [3:0]       data_be_i;
   logic [31:0]      data_addr_i;
   logic [31:0]      data_wdata_i;
   logic [31:0]      data_rdata_o;
   logic             data_err_o;

   logic [BeatW-1:0] pad_out_o;
   logic             pad_out_valid_o;
   logic [BeatW-1:0] pad_in_i;
   logic             pad_in_valid_i;

   modport slave (
      input  instr_req_i, instr_addr_i,
      input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
      input  pad_in_i, pad_in_valid_i,
      output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
      output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
      output pad_out_o, pad_out_valid_o
   );

   modport master (
      output instr_req_i, instr_addr_i,
      output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
      output pad_in_i, pad_in_valid_i,
      input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
      input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
      input  pad_out_o, pad_out_valid_o
   );

endinterface

// File: rtl/ibex_pad_mem_ctrl_rr_arb.sv
// Two-way round-robin arbiter; req[0] = instr, req[1] = data.
// On a tie the port that was not served last wins; reset favours instr.
module ibex_pad_rr_arb (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] i_req,
   input  logic       i_adv,
   output logic [1:0] o_gnt
);

   logic r_last_data;

   always_comb begin
      o_gnt = 2'b00;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = r_last_data ? 2'b01 : 2'b10;
         default: o_gnt = 2'b00;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni)    r_last_data <= 1'b1;
      else if (i_adv) r_last_data <= o_gnt[1];
   end

endmodule

// File: rtl/ibex_pad_mem_ctrl.sv
// Serialises one OBI transaction at a time onto an 8-bit pad link and
// reassembles the response; instr and data ports share the link round-robin.
module ibex_pad_mem_ctrl
   import ibex_pad_pkg::*;
#(
   parameter int TimeoutCycles = 64,
   parameter int TimeoutW      = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   ibex_pad_mem_ctrl_if.slave bus
);

   localparam logic [TimeoutW-1:0] TmoLim = TimeoutW'(TimeoutCycles);
   localparam bit                  TmoEn  = (TimeoutCycles != 0);

   pad_state_e         r_state, w_state_nxt;
   pad_cmd_e           r_cmd;
   logic [3:0]         r_be;
   logic [31:0]        r_addr, r_wdata, r_rdata;
   logic               r_err;
   logic               r_owner_data;
   logic [1:0]         r_beat;
   logic [TimeoutW-1:0] r_tmo;
   logic [31:0]        r_instr_rdata, r_data_rdata;
   logic               r_instr_err, r_data_err;

   logic [1:0]         w_req, w_gnt;
   logic               w_grant;
   logic [4:0]         w_bsel;
   logic               w_tmo_hit, w_beat_take, w_last_beat, w_resp_done;
   logic               w_instr_rv, w_data_rv;
   logic [BeatW-1:0]   w_pad_out;
   logic               w_pad_vld;

   // Requests only reach the arbiter in IDLE and out of reset, so gnt is IDLE-only.
   assign w_req   = (r_state == IDLE && rst_ni) ? {bus.data_req_i, bus.instr_req_i} : 2'b00;
   assign w_grant = |w_gnt;

   ibex_pad_rr_arb u_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .i_req  (w_req),
      .i_adv  (w_grant),
      .o_gnt  (w_gnt)
   );

   assign w_bsel      = {r_beat, 3'b000};
   assign w_tmo_hit   = TmoEn && (r_state == RESP) && (r_tmo == TmoLim);
   assign w_beat_take = (r_state == RESP) && bus.pad_in_valid_i && !w_tmo_hit;
   assign w_last_beat = (r_cmd == DWRITE) || (r_beat == 2'(DataBeats - 1));
   assign w_resp_done = w_beat_take && w_last_beat;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_grant) w_state_nxt = HDR;
         HDR:     w_state_nxt = ADDR;
         ADDR:    if (r_beat == 2'(AddrBeats - 1))
                     w_state_nxt = (r_cmd == DWRITE) ? WDATA : RESP;
         WDATA:   if (r_beat == 2'(DataBeats - 1)) w_state_nxt = RESP;
         RESP:    if (w_tmo_hit || w_resp_done) w_state_nxt = RSPV;
         RSPV:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_cmd         <= IFETCH;
         r_be          <= '0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_rdata       <= '0;
         r_err         <= 1'b0;
         r_owner_data  <= 1'b0;
         r_beat        <= '0;
         r_tmo         <= '0;
         r_instr_rdata <= '0;
         r_instr_err   <= 1'b0;
         r_data_rdata  <= '0;
         r_data_err    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant) begin
                  r_owner_data <= w_gnt[1];
                  r_cmd        <= w_gnt[0] ? IFETCH : (bus.data_we_i ? DWRITE : DREAD);
                  r_be         <= w_gnt[0] ? 4'hF : bus.data_be_i;
                  r_addr       <= w_gnt[0] ? bus.instr_addr_i : bus.data_addr_i;
                  r_wdata      <= w_gnt[0] ? 32'h0 : bus.data_wdata_i;
                  r_rdata      <= '0;
                  r_err        <= 1'b0;
                  r_beat       <= '0;
                  r_tmo        <= '0;
               end
            end
            ADDR, WDATA: r_beat <= r_beat + 2'd1;
            RESP: begin
               if (w_tmo_hit) begin
                  r_rdata <= '0;
                  r_err   <= 1'b1;
               end else if (bus.pad_in_valid_i) begin
                  r_tmo  <= '0;
                  r_beat <= r_beat + 2'd1;
                  if (r_cmd == DWRITE) r_err <= bus.pad_in_i[0];
                  else                 r_rdata[w_bsel +: BeatW] <= bus.pad_in_i;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            // Owner's result is parked here so it stays visible after RSPV.
            RSPV: begin
               if (r_owner_data) begin
                  r_data_rdata <= r_rdata;
                  r_data_err   <= r_err;
               end else begin
                  r_instr_rdata <= r_rdata;
                  r_instr_err   <= r_err;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_pad_out = '0;
      w_pad_vld = 1'b0;
      case (r_state)
         HDR: begin
            w_pad_vld = 1'b1;
            w_pad_out = hdr_beat(r_cmd, r_be);
         end
         ADDR: begin
            w_pad_vld = 1'b1;
            w_pad_out = r_addr[w_bsel +: BeatW];
         end
         WDATA: begin
            w_pad_vld = 1'b1;
            w_pad_out = r_wdata[w_bsel +: BeatW];
         end
         default: ;
      endcase
   end

   assign w_instr_rv = (r_state == RSPV) && !r_owner_data;
   assign w_data_rv  = (r_state == RSPV) &&  r_owner_data;

   assign bus.instr_gnt_o     = w_gnt[0];
   assign bus.instr_rvalid_o  = w_instr_rv;
   assign bus.instr_rdata_o   = w_instr_rv ? r_rdata : r_instr_rdata;
   assign bus.instr_err_o     = w_instr_rv ? r_err   : r_instr_err;

   assign bus.data_gnt_o      = w_gnt[1];
   assign bus.data_rvalid_o   = w_data_rv;
   assign bus.data_rdata_o    = w_data_rv ? r_rdata : r_data_rdata;
   assign bus.data_err_o      = w_data_rv ? r_err   : r_data_err;

   assign bus.pad_out_o       = w_pad_out;
   assign bus.pad_out_valid_o = w_pad_vld;

endmodule

// File: tb/tb_ibex_pad_mem_ctrl.sv
// Bench for ibex_pad_mem_ctrl: expected pad beats and responses are queued as
// stimulus is issued and checked by a negedge monitor when the DUT emits them.
module tb_ibex_pad_mem_ctrl;
   import ibex_pad_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ibex_pad_mem_ctrl_if bus();

   ibex_pad_mem_ctrl #(.TimeoutCycles(16), .TimeoutW(8)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct {
      bit          is_data;
      bit          chk_rdata;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic [7:0] exp_pad[$];
   exp_t       exp_rsp[$];
   int         n_cmp = 0;
   int         n_mis = 0;
   int         gnt_cycles = 0;
   bit         mon_en = 1'b0;
   logic [7:0] m_pb;
   exp_t       m_er;

   // Scoreboard monitor
   always @(negedge clk) begin
      if (bus.instr_gnt_o || bus.data_gnt_o) gnt_cycles++;
      if (mon_en) begin
         n_cmp++;
         if (bus.pad_out_valid_o) begin
            if (exp_pad.size() == 0) begin
               n_mis++;
               $display("FAIL pad_beat: got %h, required no beat", bus.pad_out_o);
            end else begin
               m_pb = exp_pad.pop_front();
               if (bus.pad_out_o !== m_pb) begin
                  n_mis++;
                  $display("FAIL pad_beat: got %h, required %h", bus.pad_out_o, m_pb);
               end
            end
         end else if (bus.pad_out_o !== 8'h00) begin
            n_mis++;
            $display("FAIL pad_idle: got %h, required 00", bus.pad_out_o);
         end
         n_cmp++;
         if ((bus.instr_gnt_o && bus.data_gnt_o) ||
             ((bus.instr_gnt_o || bus.data_gnt_o) &&
              (bus.pad_out_valid_o || bus.instr_rvalid_o || bus.data_rvalid_o))) begin
            n_mis++;
            $display("FAIL gnt_legal: got gnt i=%b d=%b while busy/both, required single gnt in IDLE",
                     bus.instr_gnt_o, bus.data_gnt_o);
         end
         if (bus.instr_rvalid_o && bus.data_rvalid_o) begin
            n_cmp++; n_mis++;
            $display("FAIL rvalid_both: got both rvalid, required one");
         end else if (bus.instr_rvalid_o || bus.data_rvalid_o) begin
            n_cmp++;
            if (exp_rsp.size() == 0) begin
               n_mis++;
               $display("FAIL rvalid_unexpected: got rvalid d=%b, required none", bus.data_rvalid_o);
            end else begin
               m_er = exp_rsp.pop_front();
               if (m_er.is_data !== bus.data_rvalid_o) begin
                  n_mis++;
                  $display("FAIL rvalid_port: got data=%b, required data=%b", bus.data_rvalid_o, m_er.is_data);
               end else if (m_er.is_data && ((bus.data_err_o !== m_er.err) ||
                            (m_er.chk_rdata && bus.data_rdata_o !== m_er.rdata))) begin
                  n_mis++;
                  $display("FAIL data_resp: got rdata %h err %b, required rdata %h err %b",
                           bus.data_rdata_o, bus.data_err_o, m_er.rdata, m_er.err);
               end else if (!m_er.is_data && ((bus.instr_err_o !== m_er.err) ||
                            (m_er.chk_rdata && bus.instr_rdata_o !== m_er.rdata))) begin
                  n_mis++;
                  $display("FAIL instr_resp: got rdata %h err %b, required rdata %h err %b",
                           bus.instr_rdata_o, bus.instr_err_o, m_er.rdata, m_er.err);
               end
            end
         end
      end
   end

   task automatic push_exp(input bit is_data, input bit we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rword, input bit no_resp);
      logic [1:0] cmd;
      logic [3:0] b;
      bit         wr;
      exp_t       e;
      wr  = is_data && we;
      cmd = !is_data ? 2'b01 : (we ? 2'b11 : 2'b10);
      b   = is_data ? be : 4'hF;
      exp_pad.push_back({cmd, b, 2'b00});
      for (int i = 0; i < 4; i++) exp_pad.push_back(addr[8*i +: 8]);
      if (wr) for (int i = 0; i < 4; i++) exp_pad.push_back(wdata[8*i +: 8]);
      e.is_data   = is_data;
      e.chk_rdata = no_resp || !wr;
      e.rdata     = no_resp ? 32'h0 : rword;
      e.err       = no_resp ? 1'b1 : (wr ? rword[0] : 1'b0);
      exp_rsp.push_back(e);
   endtask

   task automatic req_port(input bit is_data, input bit we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
      bit ok;
      @(posedge clk); #1;
      if (is_data) begin
         bus.data_we_i    = we;
         bus.data_be_i    = be;
         bus.data_addr_i  = addr;
         bus.data_wdata_i = wdata;
         bus.data_req_i   = 1'b1;
      end else begin
         bus.instr_addr_i = addr;
         bus.instr_req_i  = 1'b1;
      end
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (is_data ? bus.data_gnt_o : bus.instr_gnt_o) ok = 1'b1;
      end
      n_cmp++;
      if (!ok) begin
         n_mis++;
         $display("FAIL grant_wait: got no gnt for data=%b, required gnt within 50 cycles", is_data);
      end
      @(posedge clk); #1;
      bus.instr_req_i = 1'b0;
      bus.data_req_i  = 1'b0;
   endtask

   // Waits out the pad-out phase, drives response beats, returns cycles to rvalid.
   task automatic respond(input bit is_data, input int nbeats, input logic [31:0] rword,
                          input int first_gap, input int gapmax, input bit no_resp,
                          output int lat);
      int w;
      int g;
      bit rv;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (bus.pad_out_valid_o && w < 20);
      if (!no_resp) begin
         for (int k = 0; k < nbeats; k++) begin
            g = (k == 0) ? first_gap : ((gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
            repeat (g) @(negedge clk);
            bus.pad_in_i       = rword[8*k +: 8];
            bus.pad_in_valid_i = 1'b1;
            @(negedge clk);
            bus.pad_in_valid_i = 1'b0;
            bus.pad_in_i       = 8'h00;
         end
      end
      lat = no_resp ? 0 : 1;
      rv  = is_data ? bus.data_rvalid_o : bus.instr_rvalid_o;
      while (!rv && lat < 60) begin
         @(negedge clk);
         lat++;
         rv = is_data ? bus.data_rvalid_o : bus.instr_rvalid_o;
      end
      if (!rv) lat = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.instr_req_i = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({bus.instr_gnt_o, bus.data_gnt_o, bus.instr_rvalid_o, bus.data_rvalid_o,
           bus.pad_out_valid_o, bus.instr_err_o, bus.data_err_o} !== 7'b0) begin
         n_mis++;
         $display("FAIL reset_ctrl: got %b, required 0000000", {bus.instr_gnt_o, bus.data_gnt_o,
                  bus.instr_rvalid_o, bus.data_rvalid_o, bus.pad_out_valid_o, bus.instr_err_o, bus.data_err_o});
      end
      n_cmp++;
      if (bus.pad_out_o !== 8'h00) begin
         n_mis++;
         $display("FAIL reset_pad_out: got %h, required 00", bus.pad_out_o);
      end
      n_cmp++;
      if (bus.instr_rdata_o !== 32'h0 || bus.data_rdata_o !== 32'h0) begin
         n_mis++;
         $display("FAIL reset_rdata: got %h/%h, required 0/0", bus.instr_rdata_o, bus.data_rdata_o);
      end
      bus.instr_req_i = 1'b0;
      @(posedge clk); #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic test_fetch();
      int lat;
      exp_t e;
      foreach (e.rdata[i]) ;
      exp_pad.push_back(8'h7C); exp_pad.push_back(8'h80); exp_pad.push_back(8'h00);
      exp_pad.push_back(8'h00); exp_pad.push_back(8'h00);
      e.is_data = 1'b0; e.chk_rdata = 1'b1; e.rdata = 32'h0000_0013; e.err = 1'b0;
      exp_rsp.push_back(e);
      req_port(1'b0, 1'b0, 4'h0, 32'h0000_0080, 32'h0);
      respond(1'b0, 4, 32'h0000_0013, 0, 0, 1'b0, lat);
      n_cmp++;
      if (lat !== 1) begin
         n_mis++;
         $display("FAIL fetch_latency: got %0d cycles after last beat, required 1", lat);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus.instr_rdata_o !== 32'h0000_0013 || bus.instr_err_o !== 1'b0) begin
         n_mis++;
         $display("FAIL fetch_hold: got %h err %b, required 00000013 err 0", bus.instr_rdata_o, bus.instr_err_o);
      end
   endtask

   task automatic test_write();
      int lat;
      exp_t e;
      logic [7:0] wb [9] = '{8'hCC, 8'h04, 8'h00, 8'h00, 8'h10, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      for (int n = 0; n < 2; n++) begin
         foreach (wb[i]) exp_pad.push_back(wb[i]);
         e.is_data = 1'b1; e.chk_rdata = 1'b0; e.rdata = 32'h0; e.err = (n == 1);
         exp_rsp.push_back(e);
         req_port(1'b1, 1'b1, 4'b0011, 32'h1000_0004, 32'hDEAD_BEEF);
         respond(1'b1, 1, (n == 1) ? 32'h1 : 32'h0, 0, 0, 1'b0, lat);
         n_cmp++;
         if (lat !== 1) begin
            n_mis++;
            $display("FAIL write_latency: got %0d cycles after ack, required 1", lat);
         end
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if (bus.data_err_o !== 1'b1) begin
         n_mis++;
         $display("FAIL write_err_hold: got %b, required 1", bus.data_err_o);
      end
   endtask

   task automatic test_arbitration();
      int lat;
      int got;
      bit exp_port [3] = '{1'b0, 1'b1, 1'b0};
      logic [31:0] rw [3] = '{32'hA1A2_A3A4, 32'hB1B2_B3B4, 32'hC1C2_C3C4};
      rst_n = 1'b0;
      bus.instr_addr_i = 32'h0000_0100;
      bus.data_addr_i  = 32'h2000_0000;
      bus.data_we_i    = 1'b0;
      bus.data_be_i    = 4'hF;
      bus.instr_req_i  = 1'b1;
      bus.data_req_i   = 1'b1;
      repeat (2) @(posedge clk);
      gnt_cycles = 0;
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         got = -1;
         for (int j = 0; j < 50 && got < 0; j++) begin
            @(negedge clk);
            if (bus.instr_gnt_o)     got = 0;
            else if (bus.data_gnt_o) got = 1;
         end
         n_cmp++;
         if (got < 0 || got[0] !== exp_port[i]) begin
            n_mis++;
            $display("FAIL arb_order[%0d]: got port %0d, required %0d", i, got, exp_port[i]);
         end
         if (got < 0) break;
         push_exp(got[0], 1'b0, 4'hF, got[0] ? 32'h2000_0000 : 32'h0000_0100, 32'h0, rw[i], 1'b0);
         @(posedge clk); #1;
         if (i == 2) begin
            bus.instr_req_i = 1'b0;
            bus.data_req_i  = 1'b0;
         end
         respond(got[0], 4, rw[i], 0, 0, 1'b0, lat);
         n_cmp++;
         if (lat !== 1) begin
            n_mis++;
            $display("FAIL arb_latency[%0d]: got %0d, required 1", i, lat);
         end
      end
      bus.instr_req_i = 1'b0;
      bus.data_req_i  = 1'b0;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (gnt_cycles !== 3) begin
         n_mis++;
         $display("FAIL arb_gnt_count: got %0d gnt cycles, required 3", gnt_cycles);
      end
   endtask

   task automatic test_timeout();
      int lat;
      push_exp(1'b1, 1'b0, 4'hF, 32'h3000_0010, 32'h0, 32'h0, 1'b1);
      req_port(1'b1, 1'b0, 4'hF, 32'h3000_0010, 32'h0);
      respond(1'b1, 4, 32'h0, 0, 0, 1'b1, lat);
      n_cmp++;
      if (lat !== 17) begin
         n_mis++;
         $display("FAIL timeout_latency: got %0d cycles from RESP entry, required 17", lat);
      end
      push_exp(1'b1, 1'b0, 4'hF, 32'h3000_0014, 32'h0, 32'hCAFE_F00D, 1'b0);
      req_port(1'b1, 1'b0, 4'hF, 32'h3000_0014, 32'h0);
      respond(1'b1, 4, 32'hCAFE_F00D, 10, 0, 1'b0, lat);
      n_cmp++;
      if (lat !== 1) begin
         n_mis++;
         $display("FAIL timeout_restart: got %0d, required 1", lat);
      end
   endtask

   task automatic test_reset_midflight();
      int lat;
      int rv_seen;
      push_exp(1'b0, 1'b0, 4'hF, 32'h0012_3400, 32'h0, 32'h0, 1'b0);
      req_port(1'b0, 1'b0, 4'h0, 32'h0012_3400, 32'h0);
      repeat (4) @(negedge clk);
      n_cmp++;
      if (bus.pad_out_valid_o !== 1'b1 || bus.pad_out_o !== 8'h12) begin
         n_mis++;
         $display("FAIL midflight_beat: got v=%b %h, required v=1 12", bus.pad_out_valid_o, bus.pad_out_o);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_pad.delete();
      exp_rsp.delete();
      n_cmp++;
      if ({bus.pad_out_valid_o, bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_gnt_o,
           bus.data_gnt_o, bus.instr_err_o, bus.data_err_o} !== 7'b0 || bus.pad_out_o !== 8'h00 ||
          bus.instr_rdata_o !== 32'h0 || bus.data_rdata_o !== 32'h0) begin
         n_mis++;
         $display("FAIL midflight_outputs: got v=%b pad=%h ird=%h drd=%h, required all 0",
                  bus.pad_out_valid_o, bus.pad_out_o, bus.instr_rdata_o, bus.data_rdata_o);
      end
      rv_seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.instr_rvalid_o || bus.data_rvalid_o) rv_seen++;
      end
      n_cmp++;
      if (rv_seen !== 0) begin
         n_mis++;
         $display("FAIL midflight_rvalid: got %0d rvalids, required 0", rv_seen);
      end
      push_exp(1'b0, 1'b0, 4'hF, 32'h0000_0800, 32'h0, 32'h0000_0093, 1'b0);
      @(posedge clk); #1;
      bus.instr_addr_i = 32'h0000_0800;
      bus.data_addr_i  = 32'h4000_0000;
      bus.data_we_i    = 1'b0;
      bus.instr_req_i  = 1'b1;
      bus.data_req_i   = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.instr_gnt_o !== 1'b1 || bus.data_gnt_o !== 1'b0) begin
         n_mis++;
         $display("FAIL post_reset_tie: got gnt i=%b d=%b, required i=1 d=0", bus.instr_gnt_o, bus.data_gnt_o);
      end
      @(posedge clk); #1;
      bus.instr_req_i = 1'b0;
      bus.data_req_i  = 1'b0;
      respond(1'b0, 4, 32'h0000_0093, 0, 0, 1'b0, lat);
      n_cmp++;
      if (lat !== 1) begin
         n_mis++;
         $display("FAIL post_reset_fetch: got %0d, required 1", lat);
      end
   endtask

   task automatic test_gaps();
      int lat;
      push_exp(1'b1, 1'b0, 4'hF, 32'h5000_0000, 32'h0, 32'h4433_2211, 1'b0);
      req_port(1'b1, 1'b0, 4'hF, 32'h5000_0000, 32'h0);
      respond(1'b1, 4, 32'h4433_2211, 3, 12, 1'b0, lat);
      n_cmp++;
      if (lat !== 1) begin
         n_mis++;
         $display("FAIL gaps_data: got %0d, required 1", lat);
      end
      push_exp(1'b0, 1'b0, 4'hF, 32'h0000_0C40, 32'h0, 32'hA5C3_0F96, 1'b0);
      req_port(1'b0, 1'b0, 4'h0, 32'h0000_0C40, 32'h0);
      respond(1'b0, 4, 32'hA5C3_0F96, 15, 15, 1'b0, lat);
      n_cmp++;
      if (lat !== 1) begin
         n_mis++;
         $display("FAIL gaps_instr: got %0d, required 1", lat);
      end
   endtask

   initial begin
      bus.instr_req_i    = 1'b0;
      bus.instr_addr_i   = 32'h0;
      bus.data_req_i     = 1'b0;
      bus.data_we_i      = 1'b0;
      bus.data_be_i      = 4'h0;
      bus.data_addr_i    = 32'h0;
      bus.data_wdata_i   = 32'h0;
      bus.pad_in_i       = 8'h00;
      bus.pad_in_valid_i = 1'b0;
      test_reset();
      test_fetch();
      test_write();
      test_arbitration();
      test_timeout();
      test_reset_midflight();
      test_gaps();
      repeat (3) @(negedge clk);
      n_cmp++;
      if (exp_pad.size() != 0 || exp_rsp.size() != 0) begin
         n_mis++;
         $display("FAIL drain: got %0d beats / %0d responses outstanding, required 0/0",
                  exp_pad.size(), exp_rsp.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
